// File: rtl/trivium_xor_stream.sv
// trivium_xor_stream: buffers Trivium keystream bytes in a small FIFO and XORs
// each one with an incoming data byte, presenting the result on a registered
// valid/ready output. Throttles the generator via ks_enable so that bytes
// already in flight still fit.
//
// Optional feature: define TRIVIUM_XOR_STATS_EN to enable the 32-bit
// output-transfer counter on byte_count (tied to zero otherwise).
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   ks_byte, ks_valid      keystream byte from generator (no backpressure)
//   ks_enable              generator enable, high while FIFO has spare room
//   din, din_valid/ready   data byte to encrypt/decrypt
//   dout, dout_valid/ready registered XOR result
//   ks_overflow            sticky: a keystream byte was dropped (FIFO full)
//   byte_count             accepted output transfers (stats build only)
module trivium_xor_stream #(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned HEADROOM = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  ks_byte,
  input  logic        ks_valid,
  output logic        ks_enable,
  input  logic [7:0]  din,
  input  logic        din_valid,
  output logic        din_ready,
  output logic [7:0]  dout,
  output logic        dout_valid,
  input  logic        dout_ready,
  output logic        ks_overflow,
  output logic [31:0] byte_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    dout_q, dout_d;
  logic          dv_q, dv_d;
  logic          ovf_q, ovf_d;

  logic full, out_free, pop, push;

  // Handshake decode, all from registered state plus dout_ready
  assign full      = (count_q == CW'(DEPTH));
  assign out_free  = !dv_q || dout_ready;
  assign din_ready = !rst && (count_q != CW'(0)) && out_free;
  assign pop       = din_valid && din_ready;
  // A full FIFO can still accept when the same cycle frees a slot
  assign push      = ks_valid && (!full || pop);
  assign ks_enable = !rst && (count_q < CW'(DEPTH - HEADROOM));

  // Next-state for pointers, occupancy, output stage and overflow flag
  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    dout_d  = dout_q;
    dv_d    = dv_q;
    ovf_d   = ovf_q;

    if (push) wr_d = wr_q + PW'(1);

    if (pop) begin
      rd_d   = rd_q + PW'(1);
      dout_d = din ^ mem_q[rd_q];
      dv_d   = 1'b1;
    end else if (out_free) begin
      dv_d   = 1'b0;
    end

    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);

    if (ks_valid && full && !pop) ovf_d = 1'b1;
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      dout_q  <= 8'h00;
      dv_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
      dout_q  <= dout_d;
      dv_q    <= dv_d;
      ovf_q   <= ovf_d;
    end
  end

  // Keystream storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (push && !rst) mem_q[wr_q] <= ks_byte;
  end

  assign dout        = dout_q;
  assign dout_valid  = dv_q;
  assign ks_overflow = ovf_q;

`ifdef TRIVIUM_XOR_STATS_EN
  logic [31:0] bc_q;

  // Output transfer counter, wraps naturally at 2^32
  always_ff @(posedge clk) begin
    if (rst)                      bc_q <= 32'h0;
    else if (dv_q && dout_ready)  bc_q <= bc_q + 32'd1;
  end

  assign byte_count = bc_q;
`else
  assign byte_count = 32'h0;
`endif

endmodule

// File: tb/tb_trivium_xor_stream.sv
module tb_trivium_xor_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  ks_byte;
  logic        ks_valid;
  logic        ks_enable;
  logic [7:0]  din;
  logic        din_valid;
  logic        din_ready;
  logic [7:0]  dout;
  logic        dout_valid;
  logic        dout_ready;
  logic        ks_overflow;
  logic [31:0] byte_count;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q [$];
  logic [7:0] mon_e;
  logic [7:0] drain_exp [8];

  always #5 clk = ~clk;

  trivium_xor_stream #(.DEPTH(8), .HEADROOM(2)) dut (
    .clk(clk), .rst(rst),
    .ks_byte(ks_byte), .ks_valid(ks_valid), .ks_enable(ks_enable),
    .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .ks_overflow(ks_overflow), .byte_count(byte_count)
  );

  // Monitor: every accepted output must match the head of the scoreboard
  always @(negedge clk) begin
    if (!rst && dout_valid && dout_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL dout_unexpected act=%h exp=<none>", dout);
      end else begin
        mon_e = exp_q.pop_front();
        if (dout !== mon_e) begin
          bad++;
          $display("FAIL dout act=%h exp=%h", dout, mon_e);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one din byte, queue its expected result, wait (bounded) for acceptance
  task automatic send(input logic [7:0] d, input logic [7:0] e);
    int n = 0;
    exp_q.push_back(e);
    din       = d;
    din_valid = 1'b1;
    @(negedge clk);
    while (!din_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!din_ready) begin
      bad++;
      total++;
      $display("FAIL send_timeout act=%h exp=1", din_ready);
    end
    @(posedge clk);
    #1;
    din_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    drain_exp[0] = 8'h4B; drain_exp[1] = 8'h48; drain_exp[2] = 8'h49; drain_exp[3] = 8'h4E;
    drain_exp[4] = 8'h4F; drain_exp[5] = 8'h4C; drain_exp[6] = 8'h4D; drain_exp[7] = 8'h42;

    // Reset held 3 cycles with traffic offered
    rst = 1'b1; ks_valid = 1'b1; ks_byte = 8'h77;
    din_valid = 1'b1; din = 8'h11; dout_ready = 1'b1;
    step(); step(); step();
    @(negedge clk);
    chk("rst_dout", 32'(dout), 32'h00);
    chk("rst_dout_valid", 32'(dout_valid), 32'h0);
    chk("rst_overflow", 32'(ks_overflow), 32'h0);
    chk("rst_byte_count", byte_count, 32'h0);
    chk("rst_din_ready", 32'(din_ready), 32'h0);
    chk("rst_ks_enable", 32'(ks_enable), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0; ks_valid = 1'b0; din_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_empty", 32'(din_ready), 32'h0);
    chk("post_rst_ks_enable", 32'(ks_enable), 32'h1);

    // Basic XOR
    @(posedge clk); #1;
    ks_valid = 1'b1; ks_byte = 8'hA5;
    step();
    ks_valid = 1'b0;
    send(8'h3C, 8'h99);
    step();
    @(negedge clk);
    chk("basic_single_pulse", 32'(dout_valid), 32'h0);
    chk("basic_dout_hold", 32'(dout), 32'h99);

    // Ordering
    @(posedge clk); #1;
    ks_valid = 1'b1; ks_byte = 8'h01; step();
    ks_byte = 8'h02; step();
    ks_byte = 8'h03; step();
    ks_valid = 1'b0;
    send(8'hFF, 8'hFE);
    send(8'hFF, 8'hFD);
    send(8'hFF, 8'hFC);
    step();

    // Throttle: fill to 8, ks_enable drops once count reaches 6
    for (int i = 0; i < 8; i++) begin
      ks_valid = 1'b1; ks_byte = 8'(8'h10 + i);
      @(negedge clk);
      chk($sformatf("ks_enable_cnt%0d", i), 32'(ks_enable), (i < 6) ? 32'h1 : 32'h0);
      step();
    end
    ks_valid = 1'b0;
    @(negedge clk);
    chk("full_ks_enable", 32'(ks_enable), 32'h0);
    chk("full_no_overflow", 32'(ks_overflow), 32'h0);
    @(posedge clk); #1;

    // Full + simultaneous push and pop
    ks_valid = 1'b1; ks_byte = 8'h18;
    send(8'h5A, 8'h4A);
    ks_valid = 1'b0;
    @(negedge clk);
    chk("simul_no_overflow", 32'(ks_overflow), 32'h0);
    chk("simul_ks_enable", 32'(ks_enable), 32'h0);
    @(posedge clk); #1;

    // 9th byte with no pop is dropped
    ks_valid = 1'b1; ks_byte = 8'hEE;
    step();
    ks_valid = 1'b0;
    @(negedge clk);
    chk("overflow_set", 32'(ks_overflow), 32'h1);
    @(posedge clk); #1;

    // Drain: contents must be 0x11..0x18, dropped byte absent
    for (int i = 0; i < 8; i++) send(8'h5A, drain_exp[i]);
    step(); step();
    @(negedge clk);
    chk("drain_empty", 32'(din_ready), 32'h0);
    chk("overflow_sticky", 32'(ks_overflow), 32'h1);
    chk("drain_ks_enable", 32'(ks_enable), 32'h1);
    @(posedge clk); #1;

    // Backpressure
    ks_valid = 1'b1; ks_byte = 8'h0F; step();
    ks_byte = 8'hF0; step();
    ks_valid = 1'b0;
    dout_ready = 1'b0;
    exp_q.push_back(8'h3C);
    din = 8'h33; din_valid = 1'b1;
    step();
    din = 8'h44;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("bp_dout_%0d", i), 32'(dout), 32'h3C);
      chk($sformatf("bp_valid_%0d", i), 32'(dout_valid), 32'h1);
      chk($sformatf("bp_din_ready_%0d", i), 32'(din_ready), 32'h0);
      step();
    end
    exp_q.push_back(8'hB4);
    dout_ready = 1'b1;
    step();
    din_valid = 1'b0;
    step(); step();
    @(negedge clk);
    chk("bp_empty", 32'(din_ready), 32'h0);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);
`ifdef TRIVIUM_XOR_STATS_EN
    chk("byte_count", byte_count, 32'd15);
`else
    chk("byte_count", byte_count, 32'h0);
`endif
    @(posedge clk); #1;

    // Reset mid-transfer discards FIFO and pending output
    ks_valid = 1'b1; ks_byte = 8'h01; step();
    ks_byte = 8'h02; step();
    ks_valid = 1'b0;
    dout_ready = 1'b0;
    din = 8'h10; din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    @(negedge clk);
    chk("mid_pending", 32'(dout_valid), 32'h1);
    @(posedge clk); #1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", 32'(dout_valid), 32'h0);
    chk("mid_rst_dout", 32'(dout), 32'h00);
    chk("mid_rst_empty", 32'(din_ready), 32'h0);
    chk("mid_rst_overflow", 32'(ks_overflow), 32'h0);
    chk("mid_rst_byte_count", byte_count, 32'h0);
    @(posedge clk); #1;
    dout_ready = 1'b1;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/trivium_xor_stream.md
# trivium_xor_stream

Downstream consumer of the Trivium keystream generator. Buffers keystream bytes in a small FIFO, pairs each buffered byte with one incoming data byte, and emits the XOR (ciphertext or recovered plaintext) on a registered valid/ready output. Throttles the generator through its enable input so keystream bytes are never lost under normal operation.

## Interface
- `DEPTH`, 8: keystream FIFO depth in bytes; power of two, ≥4.
- `HEADROOM`, 2: free slots held in reserve to absorb generator bytes already in flight after `ks_enable` drops; must be < `DEPTH`.
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `ks_byte`  in  8  keystream byte from generator.
- `ks_valid`  in  1  `ks_byte` valid this cycle. No backpressure on this input.
- `ks_enable`  out  1  enable to generator; high while FIFO has room beyond headroom.
- `din`  in  8  data byte to encrypt/decrypt.
- `din_valid`  in  1  `din` valid.
- `din_ready`  out  1  `din` accepted when `din_valid && din_ready`.
- `dout`  out  8  `din ^ keystream`.
- `dout_valid`  out  1  `dout` valid.
- `dout_ready`  in  1  downstream accepts `dout`.
- `ks_overflow`  out  1  sticky: keystream byte dropped because FIFO was full.
- `byte_count`  out  32  bytes transferred on output (only with `TRIVIUM_XOR_STATS_EN`).

## Operation
- FIFO: `DEPTH` entries, read/write pointers `log2(DEPTH)` bits wrapping modulo `DEPTH`, occupancy counter `0..DEPTH`.
- Push: `ks_valid` and (`count < DEPTH` or a pop occurs the same cycle). Full with no pop: byte dropped, `ks_overflow` set, held until `rst`.
- Output stage free: `!dout_valid || dout_ready`.
- `din_ready = (count != 0) && output stage free`. Combinational from registered state and `dout_ready` only; it never depends on `din_valid`.
- Pop/transfer: `din_valid && din_ready`. On that edge `dout <= din ^ fifo[rd_ptr]`, `dout_valid <= 1`, and `rd_ptr` advances.
- Output stage free with no transfer: `dout_valid <= 0`. `dout` holds its last value.
- `dout` and `dout_valid` stay stable while `dout_valid && !dout_ready`.
- `ks_enable = !rst && (count < DEPTH - HEADROOM)`, decoded from the registered count.
- Push and pop in the same cycle: count unchanged, both pointers advance. This applies at full and at empty+1 alike.
- Empty FIFO: `din_ready = 0`. Same-cycle bypass of a just-pushed byte is not allowed; a pushed byte is poppable the following cycle.
- Keystream bytes are consumed strictly in arrival order. Each byte is used exactly once.

## Timing
- Reset (edge sampled with `rst = 1`) gives: `count = 0`, pointers 0, `dout = 0x00`, `dout_valid = 0`, `ks_overflow = 0`, `byte_count = 0`.
- While `rst` is high: `din_ready = 0` and `ks_enable = 0`.
- Reset asserted mid-transfer discards all FIFO contents and any pending `dout` on that edge.
- Latency: keystream push at edge N makes the byte poppable at edge N+1. `din` accepted at edge M gives `dout_valid` from M through at least the next cycle.
- Throughput: one byte per cycle sustained when the FIFO is non-empty and `dout_ready = 1`.
- `ks_enable` deasserts the cycle after `count` reaches `DEPTH - HEADROOM`. It reasserts the cycle after `count` drops below that value.

## Configuration
- `TRIVIUM_XOR_STATS_EN` defined:
  - `byte_count` increments by 1 on each `dout_valid && dout_ready` and wraps at 2^32.
  - Reset value 0.
- `TRIVIUM_XOR_STATS_EN` undefined:
  - Counter logic omitted.
  - `byte_count` tied to `32'h0`.
  - All other behaviour identical.

## Test plan
- Reset: hold `rst` 3 cycles with `ks_valid = 1` and `din_valid = 1` -> all outputs at reset values, no push, `count` stays 0.
- Basic XOR: push `ks_byte` 0xA5, then `din` 0x3C with `dout_ready = 1` -> `dout = 0x99`, `dout_valid` high for one cycle.
- Ordering: push 0x01, 0x02, 0x03, then `din` 0xFF ×3 -> `dout` 0xFE, 0xFD, 0xFC in order.
- Throttle with `DEPTH = 8`, `HEADROOM = 2`, no `din`, `ks_valid` continuous:
  - `ks_enable` falls the cycle after `count` hits 6.
  - A 9th byte with no pop -> `ks_overflow = 1`, FIFO contents unchanged.
- Backpressure: hold `dout_ready = 0` for 4 cycles with `din_valid = 1` -> `dout` and `dout_valid` stable, `din_ready = 0`, exactly one keystream byte consumed.
- Full + simultaneous: FIFO full, `ks_valid = 1` and a pop in the same cycle -> `count` stays 8, no overflow. With the macro defined, `byte_count` matches the number of accepted outputs.
